// File: rtl/depth_test_writeback.sv
// depth_test_writeback: final rasterizer stage. Buffers incoming fragments in a
// small FIFO, performs an unsigned depth test (pass iff new < old) and writes
// colour then depth of passing fragments over an Avalon-MM master.
module depth_test_writeback #(
  parameter int FIFO_DEPTH  = 8,
  parameter int STALL_SLACK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [25:0] addr_in,
  input  logic [31:0] old_depth_in,
  input  logic [31:0] new_depth_in,
  input  logic [23:0] color_in,
  input  logic        done_in,
  output logic        stall_out,
  output logic [25:0] master_address,
  output logic        master_write,
  output logic        master_read,
  output logic [3:0]  master_byteenable,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest,
  output logic        done_out,
  output logic        overflow,
  output logic [31:0] pass_count,
  output logic [31:0] fail_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic        done;
    logic [23:0] color;
    logic [31:0] new_depth;
    logic [31:0] old_depth;
    logic [25:0] addr;
  } frag_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_COLOR,
    S_WR_DEPTH,
    S_DONE
  } state_t;

  state_t state, state_next;

  frag_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic             full, empty, push, pop;
  frag_t            head;
  logic             head_pass;

  // Working register: the fragment currently being written out.
  logic [25:0] wk_addr;
  logic [23:0] wk_color;
  logic [31:0] wk_depth;
  logic        wk_done;

  assign full      = (occupancy == CNT_W'(FIFO_DEPTH));
  assign empty     = (occupancy == '0);
  assign push      = in_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr];
  assign head_pass = (head.new_depth < head.old_depth);
  // Upstream keeps delivering in-flight reads after stall; stall never gates push.
  assign stall_out   = (occupancy >= CNT_W'(FIFO_DEPTH - STALL_SLACK));
  assign master_read = 1'b0;

  // Fragment storage; data path needs no reset because occupancy guards reads.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{done: done_in, color: color_in, new_depth: new_depth_in,
                             old_depth: old_depth_in, addr: addr_in};
    end
  end

  // Load the head fragment into the working register when it is popped.
  always_ff @(posedge clock) begin
    if (pop) begin
      wk_addr  <= head.addr;
      wk_color <= head.color;
      wk_depth <= head.new_depth;
      wk_done  <= head.done;
    end
  end

  // Control state: FSM, FIFO pointers/occupancy, sticky overflow and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      overflow   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (in_valid && full) overflow <= 1'b1;
      if (pop && !head_pass) fail_count <= fail_count + 32'd1;
      if (state == S_WR_DEPTH && !master_waitrequest) pass_count <= pass_count + 32'd1;
    end
  end

  // Next-state logic: one pop per IDLE cycle, two Avalon writes per passing fragment.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head_pass)      state_next = S_WR_COLOR;
          else if (head.done) state_next = S_DONE;
          else                state_next = S_IDLE;
        end
      end
      S_WR_COLOR: begin
        if (!master_waitrequest) state_next = S_WR_DEPTH;
      end
      S_WR_DEPTH: begin
        if (!master_waitrequest) state_next = wk_done ? S_DONE : S_IDLE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore master outputs: held stable from state and working register during waitrequest.
  always_comb begin
    master_write      = 1'b0;
    master_address    = '0;
    master_writedata  = '0;
    master_byteenable = '0;
    done_out          = 1'b0;
    case (state)
      S_WR_COLOR: begin
        master_write      = 1'b1;
        master_address    = wk_addr;
        master_writedata  = {8'h00, wk_color};
        master_byteenable = 4'b1111;
      end
      S_WR_DEPTH: begin
        master_write      = 1'b1;
        master_address    = wk_addr + 26'd4;
        master_writedata  = wk_depth;
        master_byteenable = 4'b1111;
      end
      S_DONE:  done_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_depth_test_writeback.sv
// Testbench for depth_test_writeback: table-driven single-fragment vectors plus
// hand-written sequences for latency, waitrequest, back-pressure, done and reset.
module tb_depth_test_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [25:0] addr_in;
  logic [31:0] old_depth_in;
  logic [31:0] new_depth_in;
  logic [23:0] color_in;
  logic        done_in;
  logic        stall_out;
  logic [25:0] master_address;
  logic        master_write;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic        master_waitrequest;
  logic        done_out;
  logic        overflow;
  logic [31:0] pass_count;
  logic [31:0] fail_count;

  always #5 clock = ~clock;

  depth_test_writeback #(.FIFO_DEPTH(8), .STALL_SLACK(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .addr_in(addr_in),
    .old_depth_in(old_depth_in), .new_depth_in(new_depth_in), .color_in(color_in),
    .done_in(done_in), .stall_out(stall_out), .master_address(master_address),
    .master_write(master_write), .master_read(master_read),
    .master_byteenable(master_byteenable), .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest), .done_out(done_out), .overflow(overflow),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  typedef struct {
    logic [25:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } wr_t;

  wr_t wrlog[$];
  int  done_cyc[$];
  int  write_cycles = 0;
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;

  // Bus monitor: samples mid-cycle, logs accepted writes and done pulses.
  always begin
    @(negedge clock);
    #2;
    if (master_write) begin
      write_cycles++;
      if (!master_waitrequest)
        wrlog.push_back('{master_address, master_writedata, master_byteenable, cyc});
    end
    if (done_out) done_cyc.push_back(cyc);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic push(input logic [25:0] a, input logic [31:0] o, input logic [31:0] n,
                      input logic [23:0] c, input logic d);
    in_valid = 1'b1; addr_in = a; old_depth_in = o; new_depth_in = n;
    color_in = c; done_in = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [25:0] addr;
    logic [31:0] old_d;
    logic [31:0] new_d;
    logic [23:0] color;
    logic        pass;
    logic [25:0] daddr;
  } vec_t;

  vec_t vecs[6];
  int   exp_pass = 0;
  int   exp_fail = 0;
  logic stall_exp[9];

  initial begin
    int base, p, wc0, nd;
    vecs[0] = '{26'h0000200, 32'h00009000, 32'h00008000, 24'h123456, 1'b1, 26'h0000204};
    vecs[1] = '{26'h0000300, 32'h00008000, 32'h00009000, 24'h654321, 1'b0, 26'h0000304};
    vecs[2] = '{26'h0000304, 32'h00008000, 32'h00008000, 24'h111111, 1'b0, 26'h0000308};
    vecs[3] = '{26'h3FFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 24'hFEDCBA, 1'b1, 26'h0000002};
    vecs[4] = '{26'h0000040, 32'h80000000, 32'h00000001, 24'h0F0F0F, 1'b1, 26'h0000044};
    vecs[5] = '{26'h0000050, 32'h00000001, 32'h80000000, 24'hF0F0F0, 1'b0, 26'h0000054};
    stall_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; addr_in = '0; old_depth_in = '0; new_depth_in = '0;
    color_in = '0; done_in = 1'b0; master_waitrequest = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_stall", stall_out, 0);
    check("rst_write", master_write, 0);
    check("rst_read", master_read, 0);
    check("rst_addr", master_address, 0);
    check("rst_wdata", master_writedata, 0);
    check("rst_be", master_byteenable, 0);
    check("rst_done", done_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single pass with cycle-exact latency.
    base = wrlog.size();
    push(26'h100, 32'h8000, 32'h4000, 24'hABCDEF, 1'b0);
    check("lat_n1_write", master_write, 0);
    @(negedge clock);
    check("lat_n2_write", master_write, 1);
    check("lat_n2_addr", master_address, 26'h100);
    check("lat_n2_data", master_writedata, 32'h00ABCDEF);
    check("lat_n2_be", master_byteenable, 4'b1111);
    @(negedge clock);
    check("lat_n3_write", master_write, 1);
    check("lat_n3_addr", master_address, 26'h104);
    check("lat_n3_data", master_writedata, 32'h00004000);
    check("lat_n3_be", master_byteenable, 4'b1111);
    @(negedge clock);
    check("lat_n4_write", master_write, 0);
    exp_pass++;
    check("lat_pass_cnt", pass_count, exp_pass);
    check("lat_nwr", wrlog.size() - base, 2);

    // Table of single fragments.
    for (int i = 0; i < 6; i++) begin
      base = wrlog.size();
      wc0 = write_cycles;
      push(vecs[i].addr, vecs[i].old_d, vecs[i].new_d, vecs[i].color, 1'b0);
      repeat (5) @(negedge clock);
      if (vecs[i].pass) exp_pass++;
      else exp_fail++;
      check($sformatf("v%0d_nwr", i), wrlog.size() - base, vecs[i].pass ? 2 : 0);
      check($sformatf("v%0d_wcyc", i), write_cycles - wc0, vecs[i].pass ? 2 : 0);
      if (wrlog.size() - base == 2) begin
        check($sformatf("v%0d_caddr", i), wrlog[base].addr, vecs[i].addr);
        check($sformatf("v%0d_cdata", i), wrlog[base].data, {8'h00, vecs[i].color});
        check($sformatf("v%0d_cbe", i), wrlog[base].be, 4'b1111);
        check($sformatf("v%0d_daddr", i), wrlog[base+1].addr, vecs[i].daddr);
        check($sformatf("v%0d_ddata", i), wrlog[base+1].data, vecs[i].new_d);
        check($sformatf("v%0d_dbe", i), wrlog[base+1].be, 4'b1111);
      end
      check($sformatf("v%0d_pass_cnt", i), pass_count, exp_pass);
      check($sformatf("v%0d_fail_cnt", i), fail_count, exp_fail);
    end

    // Waitrequest held 5 cycles during the colour write.
    base = wrlog.size();
    p = cyc;
    push(26'h500, 32'h2, 32'h1, 24'h112233, 1'b0);
    master_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("wr_hold%0d_write", k), master_write, 1);
      check($sformatf("wr_hold%0d_addr", k), master_address, 26'h500);
      check($sformatf("wr_hold%0d_data", k), master_writedata, 32'h00112233);
    end
    @(negedge clock);
    master_waitrequest = 1'b0;
    check("wr_acc_addr", master_address, 26'h500);
    @(negedge clock);
    check("wr_depth_addr", master_address, 26'h504);
    check("wr_depth_data", master_writedata, 32'h1);
    @(negedge clock);
    check("wr_after_write", master_write, 0);
    exp_pass++;
    check("wr_nwr", wrlog.size() - base, 2);
    if (wrlog.size() - base == 2) begin
      check("wr_color_cyc", wrlog[base].cyc, p + 7);
      check("wr_depth_cyc", wrlog[base+1].cyc, p + 8);
    end
    check("wr_pass_cnt", pass_count, exp_pass);

    // Done marker on the last of three passing fragments.
    base = wrlog.size();
    nd = done_cyc.size();
    push(26'h600, 32'h10, 32'h01, 24'h000001, 1'b0);
    push(26'h610, 32'h10, 32'h02, 24'h000002, 1'b0);
    push(26'h620, 32'h10, 32'h03, 24'h000003, 1'b1);
    repeat (15) @(negedge clock);
    exp_pass += 3;
    check("done_nwr", wrlog.size() - base, 6);
    check("done_npulse", done_cyc.size() - nd, 1);
    if (wrlog.size() - base == 6 && done_cyc.size() - nd == 1) begin
      check("done_last_addr", wrlog[base+5].addr, 26'h624);
      check("done_cyc", done_cyc[nd], wrlog[base+5].cyc + 1);
    end
    check("done_pass_cnt", pass_count, exp_pass);

    // Done marker on a failing fragment.
    nd = done_cyc.size();
    p = cyc;
    push(26'h700, 32'h10, 32'h20, 24'h0, 1'b1);
    repeat (5) @(negedge clock);
    exp_fail++;
    check("fdone_npulse", done_cyc.size() - nd, 1);
    if (done_cyc.size() - nd == 1) check("fdone_cyc", done_cyc[nd], p + 2);
    check("fdone_fail_cnt", fail_count, exp_fail);

    // Back-pressure: slave stalls, FIFO fills, 10th push overflows.
    base = wrlog.size();
    master_waitrequest = 1'b1;
    for (int k = 0; k < 9; k++) begin
      push(26'h1000 + 26'(k * 16), 32'hFFFF, 32'(k), 24'(k + 1), 1'b0);
      check($sformatf("bp_stall%0d", k), stall_out, stall_exp[k]);
    end
    check("bp_ovf_before", overflow, 0);
    push(26'h2000, 32'hFFFF, 32'h0, 24'h0, 1'b0);
    check("bp_ovf_after", overflow, 1);
    master_waitrequest = 1'b0;
    repeat (40) @(negedge clock);
    exp_pass += 9;
    check("bp_nwr", wrlog.size() - base, 18);
    if (wrlog.size() - base == 18) begin
      for (int k = 0; k < 9; k++) begin
        check($sformatf("bp_c%0d_addr", k), wrlog[base+2*k].addr, 26'h1000 + 26'(k * 16));
        check($sformatf("bp_c%0d_data", k), wrlog[base+2*k].data, 32'(k + 1));
        check($sformatf("bp_d%0d_addr", k), wrlog[base+2*k+1].addr, 26'h1004 + 26'(k * 16));
      end
    end
    check("bp_pass_cnt", pass_count, exp_pass);
    check("bp_stall_drained", stall_out, 0);

    // Reset during the depth write with 3 fragments queued.
    master_waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) push(26'h3000 + 26'(k * 16), 32'hFF, 32'h1, 24'h5, 1'b0);
    master_waitrequest = 1'b0;
    @(negedge clock);
    master_waitrequest = 1'b1;
    check("rm_in_depth_write", master_write, 1);
    check("rm_in_depth_addr", master_address, 26'h3004);
    check("rm_ovf_sticky", overflow, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    master_waitrequest = 1'b0;
    check("rm_write", master_write, 0);
    check("rm_pass", pass_count, 0);
    check("rm_fail", fail_count, 0);
    check("rm_ovf", overflow, 0);
    check("rm_stall", stall_out, 0);
    base = wrlog.size();
    wc0 = write_cycles;
    repeat (20) @(negedge clock);
    check("rm_no_writes", wrlog.size() - base, 0);
    check("rm_no_write_cycles", write_cycles - wc0, 0);
    check("rm_pass_after", pass_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
